// File: rtl/video_scaler_if.sv
// Pixel-strobe / source-coordinate bundle between the LCD driver side and the scaler.
interface video_scaler_if #(
    parameter int SHW = 8,
    parameter int SVW = 7
) ();
    logic           pix_en;
    logic           frame_start;
    logic [SHW-1:0] hpos;
    logic [SVW-1:0] vpos;
    logic           active;
    logic           line_start;
    logic           frame_end;

    modport master (
        output pix_en, frame_start,
        input  hpos, vpos, active, line_start, frame_end
    );

    modport slave (
        input  pix_en, frame_start,
        output hpos, vpos, active, line_start, frame_end
    );
endinterface

// File: rtl/video_scaler.sv
// Panel-to-source coordinate scaler: integer X/Y replication, centred window,
// registered coordinates and strobes for each consumed panel pixel.
module video_scaler #(
    parameter int PANEL_W = 320,
    parameter int PANEL_H = 240,
    parameter int SRC_W   = 128,
    parameter int SRC_H   = 96,
    parameter int SCALE_X = 2,
    parameter int SCALE_Y = 2,
    parameter int HW      = 9,
    parameter int VW      = 8,
    parameter int SHW     = 8,
    parameter int SVW     = 7
) (
    input  logic         clk,
    input  logic         reset,
    video_scaler_if.slave vif
);
    localparam int WIN_W = SRC_W * SCALE_X;
    localparam int WIN_H = SRC_H * SCALE_Y;
    localparam int OFF_X = (PANEL_W - WIN_W) / 2;
    localparam int OFF_Y = (PANEL_H - WIN_H) / 2;
    localparam int SXW   = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int SYW   = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

    localparam logic [SXW-1:0] SUBX_MAX = SXW'(SCALE_X - 1);
    localparam logic [SYW-1:0] SUBY_MAX = SYW'(SCALE_Y - 1);
    localparam logic [HW-1:0]  ONE_H    = HW'(1);
    localparam logic [VW-1:0]  ONE_V    = VW'(1);
    localparam logic [SXW-1:0] ONE_SUBX = SXW'(1);
    localparam logic [SYW-1:0] ONE_SUBY = SYW'(1);
    localparam logic [SHW-1:0] ONE_SH   = SHW'(1);
    localparam logic [SVW-1:0] ONE_SV   = SVW'(1);

    localparam bit CFG_BAD = (SCALE_X < 1) || (SCALE_Y < 1) ||
                             (WIN_W > PANEL_W) || (WIN_H > PANEL_H) ||
                             (PANEL_W > (2 ** HW)) || (PANEL_H > (2 ** VW)) ||
                             (SRC_W > (2 ** SHW)) || (SRC_H > (2 ** SVW));

    if (CFG_BAD) begin : g_cfg_err
        $error("video_scaler: window larger than panel, scale < 1, or counter width too narrow");
    end

    logic [HW-1:0]  px_q, px_d, cx_s;
    logic [VW-1:0]  py_q, py_d, cy_s;
    logic [SXW-1:0] subx_q, subx_d, esubx_s;
    logic [SYW-1:0] suby_q, suby_d, esuby_s;
    logic [SHW-1:0] sx_q, sx_d, esx_s;
    logic [SVW-1:0] sy_q, sy_d, esy_s;
    logic [SHW-1:0] hpos_q, hpos_d;
    logic [SVW-1:0] vpos_q, vpos_d;
    logic           active_q, active_d;
    logic           line_start_q, line_start_d;
    logic           frame_end_q, frame_end_d;
    logic           in_x_s, in_y_s, at_x0_s, at_y0_s, last_x_s, last_y_s;

    // Next-state: position of the consumed pixel, replication counters and output values.
    always_comb begin
        px_d         = px_q;
        py_d         = py_q;
        subx_d       = subx_q;
        suby_d       = suby_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        hpos_d       = hpos_q;
        vpos_d       = vpos_q;
        active_d     = active_q;
        line_start_d = 1'b0;
        frame_end_d  = 1'b0;

        // A resync makes the pixel consumed this cycle (0,0) with fresh sub-counters.
        cx_s = vif.frame_start ? {HW{1'b0}} : px_q;
        cy_s = vif.frame_start ? {VW{1'b0}} : py_q;

        at_x0_s  = (int'(cx_s) == OFF_X);
        at_y0_s  = (int'(cy_s) == OFF_Y);
        in_x_s   = (int'(cx_s) >= OFF_X) && (int'(cx_s) < OFF_X + WIN_W);
        in_y_s   = (int'(cy_s) >= OFF_Y) && (int'(cy_s) < OFF_Y + WIN_H);
        last_x_s = (int'(cx_s) == PANEL_W - 1);
        last_y_s = (int'(cy_s) == PANEL_H - 1);

        esubx_s = (vif.frame_start || at_x0_s) ? {SXW{1'b0}} : subx_q;
        esx_s   = (vif.frame_start || at_x0_s) ? {SHW{1'b0}} : sx_q;
        esuby_s = (vif.frame_start || at_y0_s) ? {SYW{1'b0}} : suby_q;
        esy_s   = (vif.frame_start || at_y0_s) ? {SVW{1'b0}} : sy_q;

        if (vif.frame_start) begin
            px_d   = {HW{1'b0}};
            py_d   = {VW{1'b0}};
            subx_d = {SXW{1'b0}};
            suby_d = {SYW{1'b0}};
            sx_d   = {SHW{1'b0}};
            sy_d   = {SVW{1'b0}};
        end else begin
            px_d = px_q;
        end

        if (vif.pix_en) begin
            if (last_x_s) begin
                px_d = {HW{1'b0}};
                py_d = last_y_s ? {VW{1'b0}} : (cy_s + ONE_V);
            end else begin
                px_d = cx_s + ONE_H;
                py_d = cy_s;
            end

            if (in_x_s && (esubx_s == SUBX_MAX)) begin
                subx_d = {SXW{1'b0}};
                sx_d   = esx_s + ONE_SH;
            end else if (in_x_s) begin
                subx_d = esubx_s + ONE_SUBX;
                sx_d   = esx_s;
            end else begin
                subx_d = esubx_s;
                sx_d   = esx_s;
            end

            // Vertical replication steps once per panel line, at its last pixel.
            if (last_x_s && in_y_s && (esuby_s == SUBY_MAX)) begin
                suby_d = {SYW{1'b0}};
                sy_d   = esy_s + ONE_SV;
            end else if (last_x_s && in_y_s) begin
                suby_d = esuby_s + ONE_SUBY;
                sy_d   = esy_s;
            end else begin
                suby_d = esuby_s;
                sy_d   = esy_s;
            end

            active_d     = in_x_s && in_y_s;
            hpos_d       = (in_x_s && in_y_s) ? esx_s : {SHW{1'b0}};
            vpos_d       = (in_x_s && in_y_s) ? esy_s : {SVW{1'b0}};
            line_start_d = at_x0_s && in_y_s && (esuby_s == {SYW{1'b0}});
            frame_end_d  = last_x_s && last_y_s;
        end else begin
            line_start_d = 1'b0;
            frame_end_d  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_q         <= {HW{1'b0}};
            py_q         <= {VW{1'b0}};
            subx_q       <= {SXW{1'b0}};
            suby_q       <= {SYW{1'b0}};
            sx_q         <= {SHW{1'b0}};
            sy_q         <= {SVW{1'b0}};
            hpos_q       <= {SHW{1'b0}};
            vpos_q       <= {SVW{1'b0}};
            active_q     <= 1'b0;
            line_start_q <= 1'b0;
            frame_end_q  <= 1'b0;
        end else begin
            px_q         <= px_d;
            py_q         <= py_d;
            subx_q       <= subx_d;
            suby_q       <= suby_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            hpos_q       <= hpos_d;
            vpos_q       <= vpos_d;
            active_q     <= active_d;
            line_start_q <= line_start_d;
            frame_end_q  <= frame_end_d;
        end
    end

    assign vif.hpos       = hpos_q;
    assign vif.vpos       = vpos_q;
    assign vif.active     = active_q;
    assign vif.line_start = line_start_q;
    assign vif.frame_end  = frame_end_q;
endmodule

// File: tb/tb_video_scaler.sv
// Scoreboard bench: default 2x scaler and a 1:1 full-panel scaler driven with identical strobes.
module tb_video_scaler;
    typedef struct {
        int hpos;
        int vpos;
        bit active;
        bit ls;
        bit fe;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    video_scaler_if #(.SHW(8), .SVW(7)) ifa ();
    video_scaler_if #(.SHW(9), .SVW(8)) ifb ();

    video_scaler dut_a (.clk(clk), .reset(reset), .vif(ifa));

    video_scaler #(
        .PANEL_W(320), .PANEL_H(240), .SRC_W(320), .SRC_H(240),
        .SCALE_X(1), .SCALE_Y(1), .HW(9), .VW(8), .SHW(9), .SVW(8)
    ) dut_b (.clk(clk), .reset(reset), .vif(ifb));

    exp_t qa[$];
    exp_t qb[$];
    exp_t held_a, held_b, ea, eb, zero_e;
    int   checks = 0;
    int   failures = 0;
    int   cx = 0;
    int   cy = 0;
    int   act_a = 0;
    int   act_b = 0;
    bit   en_m;

    // Reference: source coordinate is the offset into the window divided by the scale.
    function automatic exp_t model(input int x, input int y, input int sw, input int sh,
                                   input int kx, input int ky);
        exp_t r;
        int ox, oy;
        bit inx, iny;
        ox = (320 - sw * kx) / 2;
        oy = (240 - sh * ky) / 2;
        inx = (x >= ox) && (x < ox + sw * kx);
        iny = (y >= oy) && (y < oy + sh * ky);
        r.active = inx && iny;
        r.hpos   = r.active ? (x - ox) / kx : 0;
        r.vpos   = r.active ? (y - oy) / ky : 0;
        r.ls     = (x == ox) && iny && (((y - oy) % ky) == 0);
        r.fe     = (x == 319) && (y == 239);
        return r;
    endfunction

    task automatic cmp(input string tag, input int hp, input int vp, input bit ac,
                       input bit ls, input bit fe, input exp_t e);
        checks++;
        if (hp != e.hpos || vp != e.vpos || ac != e.active || ls != e.ls || fe != e.fe) begin
            failures++;
            $display("FAIL %s @%0t: got hpos=%0d vpos=%0d active=%0b line_start=%0b frame_end=%0b, want hpos=%0d vpos=%0d active=%0b line_start=%0b frame_end=%0b",
                     tag, $time, hp, vp, ac, ls, fe, e.hpos, e.vpos, e.active, e.ls, e.fe);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic step(input bit en, input bit fs);
        int x, y;
        @(posedge clk);
        #2;
        ifa.pix_en = en;  ifb.pix_en = en;
        ifa.frame_start = fs;  ifb.frame_start = fs;
        if (en) begin
            x = fs ? 0 : cx;
            y = fs ? 0 : cy;
            qa.push_back(model(x, y, 128, 96, 2, 2));
            qb.push_back(model(x, y, 320, 240, 1, 1));
            cx = x + 1;
            cy = y;
            if (cx == 320) begin
                cx = 0;
                cy = (y == 239) ? 0 : y + 1;
            end
        end else if (fs) begin
            cx = 0;
            cy = 0;
        end
    endtask

    // Monitor: one scoreboard pop per consumed pixel, otherwise outputs must hold with strobes low.
    always @(posedge clk) begin
        en_m = ifa.pix_en;
        #1;
        ea = held_a;  ea.ls = 1'b0;  ea.fe = 1'b0;
        eb = held_b;  eb.ls = 1'b0;  eb.fe = 1'b0;
        if (en_m) begin
            if (qa.size() == 0 || qb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty @%0t: got pixel with no expectation, want queued entry", $time);
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                held_a = ea;
                held_b = eb;
            end
            if (ifa.active) act_a++;
            if (ifb.active) act_b++;
        end
        cmp("scaled_2x", int'(ifa.hpos), int'(ifa.vpos), ifa.active, ifa.line_start, ifa.frame_end, ea);
        cmp("scaled_1x", int'(ifb.hpos), int'(ifb.vpos), ifb.active, ifb.line_start, ifb.frame_end, eb);
    end

    initial begin
        zero_e = '{hpos: 0, vpos: 0, active: 1'b0, ls: 1'b0, fe: 1'b0};
        held_a = zero_e;
        held_b = zero_e;
        reset = 1'b1;
        ifa.pix_en = 1'b0;  ifb.pix_en = 1'b0;
        ifa.frame_start = 1'b0;  ifb.frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        cmp("reset_a", int'(ifa.hpos), int'(ifa.vpos), ifa.active, ifa.line_start, ifa.frame_end, zero_e);
        cmp("reset_b", int'(ifb.hpos), int'(ifb.vpos), ifb.active, ifb.line_start, ifb.frame_end, zero_e);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // One continuous frame, then count the active cycles it produced.
        for (int i = 0; i < 320 * 240; i++) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        check_int("active_cycles_2x", act_a, 49152);
        check_int("active_cycles_1x", act_b, 76800);

        // Sparse pixel strobes with occasional resyncs.
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 2) == 0, $urandom_range(0, 399) == 0);

        // Resync coinciding with a consumed pixel mid-frame.
        for (int i = 0; i < 500; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0);

        // Asynchronous reset between clock edges while pixels are streaming.
        #1;
        reset = 1'b1;
        ifa.pix_en = 1'b0;  ifb.pix_en = 1'b0;
        qa.delete();
        qb.delete();
        held_a = zero_e;
        held_b = zero_e;
        cx = 0;
        cy = 0;
        #1;
        cmp("async_reset_a", int'(ifa.hpos), int'(ifa.vpos), ifa.active, ifa.line_start, ifa.frame_end, zero_e);
        cmp("async_reset_b", int'(ifb.hpos), int'(ifb.vpos), ifb.active, ifb.line_start, ifb.frame_end, zero_e);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 400; i++) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        check_int("scoreboard_drained", qa.size() + qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
